// File: rtl/arith_pkg.sv
// ============================================================================
// Module  : arith_pkg
// Brief   : Shared arithmetic types and constants for the serial datapaths.
// Revision: 1.0
// ============================================================================
`default_nettype none

package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : arith_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module  : full_adder
// Brief   : One-bit full-adder cell.
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Brief   : Bit-serial WIDTH-bit subtractor (a + ~b + 1), one bit per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    // Holds the WIDTH-1 most recent sum bits; the final bit joins them at latch time.
    logic [WIDTH-2:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic               w_sum;
    logic               w_cout;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    full_adder u_slice (
        .i_a    (r_sa[0]),
        .i_b    (r_sb[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_accept   = (r_state == IDLE) && start;
    assign w_last     = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_next = {w_sum, r_res};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= a;
            r_sb    <= ~b;
            r_res   <= '0;
            r_carry <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_res   <= w_res_next[WIDTH-1:1];
            r_carry <= w_cout;
            r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= ~w_cout;
                // r_carry is the carry into the MSB on this edge.
                r_ovf  <= r_carry ^ w_cout;
            end
        end
    end

    assign diff  = r_diff;
    assign b_out = r_bout;
    assign ovf   = r_ovf;
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module  : tb_serial_subtractor
// Brief   : Directed self-checking bench for serial_subtractor (WIDTH = 8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_diff, input logic e_bout,
                             input logic e_ovf, input logic e_busy, input logic e_done);
        check({tag, ".diff"},  32'(diff),  32'(e_diff));
        check({tag, ".b_out"}, 32'(b_out), 32'(e_bout));
        check({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
        check({tag, ".busy"},  32'(busy),  32'(e_busy));
        check({tag, ".done"},  32'(done),  32'(e_done));
    endtask

    // Full transaction; prev_* are the results that must hold throughout RUN.
    task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [7:0] e_diff, input logic e_bout, input logic e_ovf,
                          input logic [7:0] p_diff, input logic p_bout, input logic p_ovf);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 8'hAA;
        b     = 8'h55;
        for (int k = 1; k < WIDTH; k++) begin
            check_all({tag, ".run"}, p_diff, p_bout, p_ovf, 1'b1, 1'b0);
            step();
        end
        check_all({tag, ".run_last"}, p_diff, p_bout, p_ovf, 1'b1, 1'b0);
        step();
        check_all({tag, ".done"}, e_diff, e_bout, e_ovf, 1'b0, 1'b1);
        step();
        check_all({tag, ".idle"}, e_diff, e_bout, e_ovf, 1'b0, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        step();
        step();
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();

        run_op("t05m03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op("t03m05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("t80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
        run_op("t00m00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1);

        // Starts at cycles 3 and 8 after the accept must be ignored.
        a     = 8'h20;
        b     = 8'h08;
        start = 1'b1;
        step();
        for (int k = 1; k <= WIDTH; k++) begin
            if (k == 3 || k == 8) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h01;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check_all("ign.done", 8'h18, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_all("ign.after1", 8'h18, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("ign.after2", 8'h18, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort mid-RUN.
        a     = 8'h40;
        b     = 8'h10;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("abort.busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all("abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("abort.idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("t10m01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset beats start; start held through reset release is accepted next edge.
        a     = 8'h01;
        b     = 8'h02;
        rst   = 1'b1;
        start = 1'b1;
        step();
        check_all("rststart.1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("rststart.2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        start = 1'b0;
        check("rststart.busy", 32'(busy), 32'd1);
        for (int k = 1; k < WIDTH; k++) step();
        check("rststart.busy_last", 32'(busy), 32'd1);
        step();
        check_all("rststart.done", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check("rststart.done_drop", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor

`default_nettype wire
